// File: rtl/txn_arbiter.sv
// txn_arbiter: two-master round-robin arbiter for the fabric32 txn bus.
// One outstanding transaction; completion follows the slave rdy handshake.
module txn_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic          txn_req,
  output logic          txn_wr,
  output logic [AW-1:0] txn_addr,
  output logic [DW-1:0] txn_wdata,
  input  logic [DW-1:0] txn_rdata,
  input  logic          txn_rdy,
  output logic          txn_err,
  output logic          done_err
);

  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic          own_q, own_d;
  logic          txn_req_q, txn_req_d;
  logic          txn_wr_q, txn_wr_d;
  logic [AW-1:0] txn_addr_q, txn_addr_d;
  logic [DW-1:0] txn_wdata_q, txn_wdata_d;
  logic          m0_gnt_q, m0_gnt_d;
  logic          m1_gnt_q, m1_gnt_d;
  logic          m0_done_q, m0_done_d;
  logic          m1_done_q, m1_done_d;
  logic          done_err_q, done_err_d;
  logic          txn_err_q, txn_err_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          win;

  // win=1 selects m1; on a tie the master other than rr wins
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      m0_req && m1_req:  win = ~rr_q;
      !m0_req && m1_req: win = 1'b1;
      default:           win = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    own_d       = own_q;
    txn_req_d   = 1'b0;
    txn_wr_d    = txn_wr_q;
    txn_addr_d  = txn_addr_q;
    txn_wdata_d = txn_wdata_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    done_err_d  = 1'b0;
    txn_err_d   = txn_err_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if ((m0_req || m1_req) && txn_rdy) begin
          own_d       = win;
          rr_d        = win;
          txn_req_d   = 1'b1;
          txn_wr_d    = win ? m1_wr : m0_wr;
          txn_addr_d  = win ? m1_addr : m0_addr;
          txn_wdata_d = win ? m1_wdata : m0_wdata;
          m0_gnt_d    = ~win;
          m1_gnt_d    = win;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!txn_rdy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          m0_done_d  = ~own_q;
          m1_done_d  = own_q;
          done_err_d = 1'b1;
          txn_err_d  = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (txn_rdy) begin
          m0_done_d = ~own_q;
          m1_done_d = own_q;
          if (!txn_wr_q) begin
            if (own_q) m1_rdata_d = txn_rdata;
            else       m0_rdata_d = txn_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b1;
      own_q       <= 1'b0;
      txn_req_q   <= 1'b0;
      txn_wr_q    <= 1'b0;
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      done_err_q  <= 1'b0;
      txn_err_q   <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      own_q       <= own_d;
      txn_req_q   <= txn_req_d;
      txn_wr_q    <= txn_wr_d;
      txn_addr_q  <= txn_addr_d;
      txn_wdata_q <= txn_wdata_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
      done_err_q  <= done_err_d;
      txn_err_q   <= txn_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign txn_req   = txn_req_q;
  assign txn_wr    = txn_wr_q;
  assign txn_addr  = txn_addr_q;
  assign txn_wdata = txn_wdata_q;
  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign done_err  = done_err_q;
  assign txn_err   = txn_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: doc/txn_arbiter.md
Name: txn_arbiter

Overview:
- Two-master, one-slave arbiter for the fabric32 memory transaction bus (txn_req/txn_wr/txn_addr/txn_wdata/txn_rdata/txn_rdy).
- Shares a single memory port between m0 (map-read engine) and m1 (path-writeback engine), or between fabric32 and a host loader.
- Uses round-robin grant and issues one outstanding transaction at a time.
- Completes each transaction by tracking the slave's rdy high->low->high handshake, and detects slaves that never acknowledge.

Parameters:
AW, 32, address width
DW, 32, data width
ACK_TIMEOUT, 16, cycles allowed in WAIT_ACK before abort (>=2)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
m0_req  in  1  level request from master 0
m0_wr  in  1  1=write, 0=read (m0)
m0_addr  in  AW  byte address (m0)
m0_wdata  in  DW  write data (m0)
m0_gnt  out  1  1-cycle pulse: m0 fields latched
m0_done  out  1  1-cycle pulse: m0 transaction finished
m0_rdata  out  DW  read data for m0, valid from m0_done and held until next m0 read completes
m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata  same as m0, for master 1
txn_req  out  1  request to slave
txn_wr  out  1  write strobe to slave
txn_addr  out  AW  address to slave
txn_wdata  out  DW  write data to slave
txn_rdata  in  DW  slave read data
txn_rdy  in  1  slave ready; high when idle, low while busy
txn_err  out  1  sticky: an ack timeout occurred
done_err  out  1  qualifies a done pulse as aborted (timeout)

Behaviour:
Reset (async, arst_n=0):
- All outputs go to 0 immediately, including txn_req.
- State=IDLE, rr pointer=1 (so m0 wins the first tie), timeout counter=0.
- Reset mid-transaction abandons it. No done pulse is produced.

States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE. All outputs are registered.

IDLE:
- If (m0_req|m1_req) && txn_rdy=1, pick the winner.
- Winner rule: only one master requesting -> it wins. Both requesting -> the master not equal to rr wins.
- On a grant: latch the winner's wr/addr/wdata onto txn_*, set txn_req=1, pulse mX_gnt, set rr=winner, go to ISSUE.
- If txn_rdy=0, no grant is made.

ISSUE:
- Lasts exactly 1 cycle. txn_req is high for exactly this cycle.
- Next edge: txn_req=0, go to WAIT_ACK, counter=0.
- txn_addr, txn_wr and txn_wdata hold their values until the next grant.

WAIT_ACK:
- txn_rdy=0 -> go to WAIT_DONE.
- Otherwise the counter increments.
- Counter reaches ACK_TIMEOUT-1 with txn_rdy still 1 -> pulse mX_done with done_err=1, set txn_err=1, go to IDLE.

WAIT_DONE:
- Waits with no timeout.
- When txn_rdy=1: for a read, capture txn_rdata into mX_rdata; pulse mX_done (done_err=0); go to IDLE.
- Writes leave mX_rdata unchanged.

Latency: against a slave that drops rdy 1 cycle after sampling req and restores it 1 cycle later, the grant edge to the done edge is 3 cycles. Back-to-back throughput is 1 transaction per 4 cycles.

Master protocol:
- A master holds req high until its gnt pulse; its fields are sampled only on the grant edge.
- req still high in the cycle after gnt is treated as a new request, arbitrated on the next IDLE.
- The request is never lost while waiting.

Mutual exclusion: at most one of m0_gnt/m1_gnt and at most one of m0_done/m1_done is high per cycle. gnt and done are never high for the same master in the same cycle.

Address/data pass through unmodified; no address translation.

Test Plan:
1. m0 read only, addr=0x40000010, model mem returns 0xDEADBEEF -> txn_req high 1 cycle with txn_addr=0x40000010, txn_wr=0; m0_done 3 cycles after m0_gnt; m0_rdata=0xDEADBEEF; m1_* quiet.
2. m1 write addr=0x40002004, wdata=0x12345678 -> model mem chip1[1]=0x12345678; m1_done pulses; m1_rdata unchanged; done_err=0.
3. m0 and m1 both hold req for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1; each grant 4 cycles apart; no overlap of txn_req.
4. Slave tied txn_rdy=1 (never acks), m0 read -> after ACK_TIMEOUT cycles in WAIT_ACK: m0_done=1 with done_err=1, txn_err=1 and stays 1; next m1 request is still served.
5. Deassert arst_n during WAIT_DONE -> txn_req, gnt, done and txn_err all 0 the same cycle; after release a new m1 request wins (rr=1 after reset does not block m1 when m0 is idle).
6. Replay the fabric32 path-write pattern (128 writes to 0x40002000+4i, data=i) through m1 while m0 issues 128 reads -> all 128 chip1 words are correct and 256 done pulses are seen in total.
